// File: rtl/mux_pkg.sv
// Shared constants, state encoding and width helpers for the operand selector stages.
package mux_pkg;

    localparam int MAX_NUM_IN = 64;

    // Never returns less than 1, so a 2-input selector still gets a 1-bit select.
    function automatic int clog2_min1(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r = r + 1;
        return r;
    endfunction

    // Width of the packed {data, sel, err} bundle carried through the registers.
    function automatic int bundle_w(input int width, input int sel_w);
        return width + sel_w + 1;
    endfunction

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } pipe_state_e;

endpackage

// File: rtl/mux_sel_comb.sv
// Combinational N:1 selector with force-to-zero and out-of-range detection.
// Zero latency; no handshake, so back-pressure is the caller's concern.
module mux_sel_comb
    import mux_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 8,
    parameter int SEL_W  = clog2_min1(NUM_IN)
) (
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    force_zero,
    output logic [WIDTH-1:0]        data,
    output logic                    err
);

    logic out_of_range;

    assign out_of_range = (int'(sel) >= NUM_IN);
    assign err          = out_of_range && !force_zero;

    // Indices past NUM_IN never match the loop, so they fall through to zero.
    always_comb begin
        data = '0;
        if (!force_zero) begin
            for (int k = 0; k < NUM_IN; k++) begin
                if (int'(sel) == k) begin
                    data = in_data[k*WIDTH +: WIDTH];
                end
            end
        end
    end

endmodule

// File: rtl/mux_sel_pipe.sv
// Registered N:1 selector with valid/ready handshake; one-cycle latency to out_*.
// A single skid entry behind the output register keeps in_ready free of any path from out_ready.
module mux_sel_pipe
    import mux_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 8,
    parameter int SEL_W  = clog2_min1(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    force_zero,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_err,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam int BW = bundle_w(WIDTH, SEL_W);

    if (NUM_IN < 2 || NUM_IN > MAX_NUM_IN) begin : g_bad_num_in
        $error("mux_sel_pipe: NUM_IN out of range 2..64");
    end
    if (SEL_W != clog2_min1(NUM_IN)) begin : g_bad_sel_w
        $error("mux_sel_pipe: SEL_W is derived from NUM_IN and must not be overridden");
    end

    logic [WIDTH-1:0] sel_data;
    logic             sel_err;
    logic [BW-1:0]    in_bundle;
    logic [BW-1:0]    out_q;
    logic [BW-1:0]    skid_q;
    pipe_state_e      state_q;
    pipe_state_e      state_d;
    logic             accept;
    logic             load_out_in;
    logic             load_out_skid;
    logic             load_skid;

    mux_sel_comb #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN),
        .SEL_W  (SEL_W)
    ) u_sel (
        .in_data    (in_data),
        .sel        (sel),
        .force_zero (force_zero),
        .data       (sel_data),
        .err        (sel_err)
    );

    assign in_bundle = {sel_data, sel, sel_err};

    // Both handshake outputs decode straight from the state register.
    assign in_ready  = (state_q != ST_FULL);
    assign out_valid = (state_q != ST_EMPTY);
    assign accept    = in_valid && in_ready;

    assign out_data = out_q[BW-1 -: WIDTH];
    assign out_sel  = out_q[SEL_W:1];
    assign out_err  = out_q[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        load_out_in   = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d     = ST_ONE;
                    load_out_in = 1'b1;
                end
            end
            ST_ONE: begin
                if (accept && out_ready) begin
                    load_out_in = 1'b1;
                end else if (accept) begin
                    state_d   = ST_FULL;
                    load_skid = 1'b1;
                end else if (out_ready) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (out_ready) begin
                    state_d       = ST_ONE;
                    load_out_skid = 1'b1;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q  <= '0;
            skid_q <= '0;
        end else begin
            if (load_out_skid) begin
                out_q <= skid_q;
            end else if (load_out_in) begin
                out_q <= in_bundle;
            end
            if (load_skid) begin
                skid_q <= in_bundle;
            end
        end
    end

endmodule

// File: tb/tb_mux_sel_pipe.sv
// Directed bench for mux_sel_pipe: an 8-input and a 6-input instance sharing clock and reset.
module tb_mux_sel_pipe;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // 8-input, 32-bit instance
    logic [8*32-1:0] in_data8;
    logic [2:0]      sel8;
    logic            fz8, in_valid8, in_ready8, out_err8, out_valid8, out_ready8;
    logic [31:0]     out_data8;
    logic [2:0]      out_sel8;

    // 6-input instance: indices 6 and 7 are out of range
    logic [6*32-1:0] in_data6;
    logic [2:0]      sel6;
    logic            fz6, in_valid6, in_ready6, out_err6, out_valid6, out_ready6;
    logic [31:0]     out_data6;
    logic [2:0]      out_sel6;

    mux_sel_pipe #(.WIDTH(32), .NUM_IN(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data8), .sel(sel8), .force_zero(fz8),
        .in_valid(in_valid8), .in_ready(in_ready8), .out_data(out_data8), .out_sel(out_sel8),
        .out_err(out_err8), .out_valid(out_valid8), .out_ready(out_ready8)
    );

    mux_sel_pipe #(.WIDTH(32), .NUM_IN(6)) dut6 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data6), .sel(sel6), .force_zero(fz6),
        .in_valid(in_valid6), .in_ready(in_ready6), .out_data(out_data6), .out_sel(out_sel6),
        .out_err(out_err6), .out_valid(out_valid6), .out_ready(out_ready6)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Returns one time unit after the next rising edge: drive and sample point.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int k = 0; k < 8; k++) in_data8[k*32 +: 32] = 32'h1000_0000 + k;
        for (int k = 0; k < 6; k++) in_data6[k*32 +: 32] = 32'h2000_0000 + k;
        rst_n = 1'b0;
        sel8 = '0; fz8 = 1'b0; in_valid8 = 1'b0; out_ready8 = 1'b1;
        sel6 = '0; fz6 = 1'b0; in_valid6 = 1'b0; out_ready6 = 1'b1;
        #12;
        chk("rst_out_valid", out_valid8, 0);
        chk("rst_out_data",  out_data8, 0);
        chk("rst_out_sel",   out_sel8, 0);
        chk("rst_out_err",   out_err8, 0);
        chk("rst_in_ready",  in_ready8, 1);
        chk("rst6_out_valid", out_valid6, 0);
        rst_n = 1'b1;
        step();

        // Single transaction, sel=5
        sel8 = 3'd5; in_valid8 = 1'b1;
        step();
        in_valid8 = 1'b0;
        chk("single_valid", out_valid8, 1);
        chk("single_data",  out_data8, 32'h1000_0005);
        chk("single_sel",   out_sel8, 5);
        chk("single_err",   out_err8, 0);
        step();
        chk("single_drain", out_valid8, 0);

        // force_zero
        sel8 = 3'd3; fz8 = 1'b1; in_valid8 = 1'b1;
        step();
        in_valid8 = 1'b0; fz8 = 1'b0;
        chk("fz_valid", out_valid8, 1);
        chk("fz_data",  out_data8, 0);
        chk("fz_err",   out_err8, 0);
        chk("fz_sel",   out_sel8, 3);
        step();

        // Out-of-range on the 6-input build
        sel6 = 3'd7; in_valid6 = 1'b1;
        step();
        chk("oor7_data", out_data6, 0);
        chk("oor7_err",  out_err6, 1);
        chk("oor7_sel",  out_sel6, 7);
        sel6 = 3'd5;
        step();
        chk("in5_data", out_data6, 32'h2000_0005);
        chk("in5_err",  out_err6, 0);
        sel6 = 3'd6;
        step();
        chk("oor6_data", out_data6, 0);
        chk("oor6_err",  out_err6, 1);
        sel6 = 3'd7; fz6 = 1'b1;
        step();
        in_valid6 = 1'b0; fz6 = 1'b0;
        chk("oor_fz_data", out_data6, 0);
        chk("oor_fz_err",  out_err6, 0);
        chk("oor_fz_rdy",  in_ready6, 1);
        step();
        chk("oor_drain", out_valid6, 0);

        // Back-pressure: fill output and skid, then drain
        out_ready8 = 1'b0;
        sel8 = 3'd1; in_valid8 = 1'b1;
        step();
        chk("bp_one_data",  out_data8, 32'h1000_0001);
        chk("bp_one_ready", in_ready8, 1);
        sel8 = 3'd2;
        step();
        chk("bp_full_ready", in_ready8, 0);
        chk("bp_full_data",  out_data8, 32'h1000_0001);
        sel8 = 3'd4;
        step();
        in_valid8 = 1'b0;
        chk("bp_hold_data",  out_data8, 32'h1000_0001);
        chk("bp_hold_sel",   out_sel8, 1);
        chk("bp_hold_valid", out_valid8, 1);
        out_ready8 = 1'b1;
        step();
        chk("bp_drain1_data",  out_data8, 32'h1000_0002);
        chk("bp_drain1_valid", out_valid8, 1);
        chk("bp_drain1_ready", in_ready8, 1);
        step();
        chk("bp_empty", out_valid8, 0);

        // Streaming at full rate
        for (int i = 0; i < 16; i++) begin
            sel8 = 3'(i % 8); in_valid8 = 1'b1;
            step();
            chk("stream_ready", in_ready8, 1);
            chk("stream_valid", out_valid8, 1);
            chk("stream_data",  out_data8, 32'h1000_0000 + (i % 8));
            chk("stream_sel",   out_sel8, i % 8);
        end
        in_valid8 = 1'b0;
        step();
        chk("stream_end", out_valid8, 0);

        // Async reset while FULL
        out_ready8 = 1'b0;
        sel8 = 3'd6; in_valid8 = 1'b1;
        step();
        sel8 = 3'd7;
        step();
        in_valid8 = 1'b0;
        chk("arst_pre_ready", in_ready8, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", out_valid8, 0);
        chk("arst_ready", in_ready8, 1);
        chk("arst_data",  out_data8, 0);
        rst_n = 1'b1;
        out_ready8 = 1'b1;
        step();
        chk("arst_no_stale1", out_valid8, 0);
        step();
        chk("arst_no_stale2", out_valid8, 0);
        sel8 = 3'd2; in_valid8 = 1'b1;
        step();
        in_valid8 = 1'b0;
        chk("arst_recover_data", out_data8, 32'h1000_0002);
        chk("arst_recover_valid", out_valid8, 1);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
